// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, forwarding and EX_MEM field definitions
// Purpose: constants shared by the execute stage and its multiplier.
// Ports: none (package).
package mips_pkg;

    // ALU operation codes carried on alu_op
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_MUL = 4'd6;

    // Forwarding select codes (2'b11 falls back to the register file)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX_MEM bus layout
    localparam int EXM_W       = 87;
    localparam int EXM_RD_LSB  = 0;
    localparam int EXM_WD_LSB  = 5;
    localparam int EXM_ALU_LSB = 37;
    localparam int EXM_ZERO    = 69;
    localparam int EXM_TGT_LSB = 70;
    localparam int EXM_TGT_W   = 12;
    localparam int EXM_WB_LSB  = 82;
    localparam int EXM_MEM_LSB = 84;

    // Branch target word address: (pc_plus4 + (imm << 2)) bits [13:2]
    function automatic logic [EXM_TGT_W-1:0] branch_tgt(input logic [31:0] pc_plus4,
                                                      input logic [31:0] imm);
        logic [31:0] t;
        t = pc_plus4 + (imm << 2);
        return t[EXM_TGT_W+1:2];
    endfunction

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Purpose: unsigned 32x32 multiply keeping the low 32 bits of the product.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_start          latch i_a/i_b and begin (ignored while running)
//   i_abort          drop any operation in progress, return to idle
//   i_hold           delay completion on the final iteration (EX_MEM stalled)
//   i_a, i_b         multiplicand, multiplier
//   o_busy           operation in progress
//   o_done           final iteration completes on this edge; o_result valid
//   o_result         low 32 bits of the product (valid with o_done)
module mul_iter
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_hold,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic        w_last;
    logic [31:0] w_sum;

    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_LAST);
    assign w_sum    = r_acc + (r_b[0] ? r_a : 32'd0);
    assign o_busy   = (r_state == S_RUN);
    assign o_done   = w_last && !i_hold && !i_abort;
    // The last partial product is folded in combinationally so the result
    // is ready on the same edge as the final iteration.
    assign o_result = w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_state <= S_RUN;
                r_a     <= i_a;
                r_b     <= i_b;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
        end else if (w_last) begin
            // A stalled EX_MEM cannot take the result, so wait here with the
            // final iteration pending rather than losing the product.
            if (!i_hold) begin
                r_state <= S_IDLE;
            end
        end else begin
            r_acc <= w_sum;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage and EX/MEM pipeline register
// Purpose: operand forwarding, ALU (single-cycle ops plus iterative MUL),
//          zero flag, branch target, and the EX_MEM register with
//          stall/flush/bubble handling.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   alu_op, alu_src     ALU operation, operand-B immediate select
//   reg_dst             destination select (1: rd_addr, 0: rt_addr)
//   cont_MEM_in         {Branch,MemRead,MemWrite}
//   contWB_in           {RegWrite,MemtoReg}
//   pc_plus4, rs_data, rt_data, imm, rt_addr, rd_addr   ID/EX values
//   fwdA, fwdB          forwarding selects; MEM_ALUout, WB_data sources
//   stall_in            hold EX_MEM
//   flush               squash the instruction in EX
//   EX_MEM              {mem[86:84],wb[83:82],tgt[81:70],zero[69],alu[68:37],wdata[36:5],rd[4:0]}
//   ex_busy             multiply in progress
module ex_stage
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int TGT_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic [2:0]        cont_MEM_in,
    input  logic [1:0]        contWB_in,
    input  logic [31:0]       pc_plus4,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [31:0]       imm,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic [1:0]        fwdA,
    input  logic [1:0]        fwdB,
    input  logic [31:0]       MEM_ALUout,
    input  logic [31:0]       WB_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic [EXM_W-1:0]  EX_MEM,
    output logic              ex_busy
);

    logic [EXM_W-1:0] r_ex_mem;
    logic             r_post_mul;
    logic [2:0]       r_m_mem;
    logic [1:0]       r_m_wb;
    logic [TGT_W-1:0] r_m_tgt;
    logic [31:0]      r_m_wdata;
    logic [4:0]       r_m_dest;

    logic [31:0]      w_a;
    logic [31:0]      w_b_fwd;
    logic [31:0]      w_b;
    logic [31:0]      w_alu;
    logic [4:0]       w_dest;
    logic [TGT_W-1:0] w_tgt;
    logic             w_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [31:0]      w_mul_result;
    logic [EXM_W-1:0] w_ex_single;
    logic [EXM_W-1:0] w_ex_mul;

    always_comb begin
        w_a = rs_data;
        case (fwdA)
            FWD_WB:  w_a = WB_data;
            FWD_MEM: w_a = MEM_ALUout;
            default: w_a = rs_data;
        endcase
        w_b_fwd = rt_data;
        case (fwdB)
            FWD_WB:  w_b_fwd = WB_data;
            FWD_MEM: w_b_fwd = MEM_ALUout;
            default: w_b_fwd = rt_data;
        endcase
    end

    assign w_b    = alu_src ? imm : w_b_fwd;
    assign w_dest = reg_dst ? rd_addr : rt_addr;
    assign w_tgt  = TGT_W'(branch_tgt(pc_plus4, imm));

    always_comb begin
        w_alu = w_a + w_b;
        case (alu_op)
            ALU_SUB: w_alu = w_a - w_b;
            ALU_AND: w_alu = w_a & w_b;
            ALU_OR:  w_alu = w_a | w_b;
            ALU_SLT: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_NOR: w_alu = ~(w_a | w_b);
            default: w_alu = w_a + w_b;
        endcase
    end

    // r_post_mul covers the one cycle after a MUL retires, when ID/EX still
    // presents the same MUL instruction; it must not be started twice.
    assign w_start = (alu_op == ALU_MUL) && !w_mul_busy && !r_post_mul
                     && !stall_in && !flush;

    mul_iter #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_abort  (flush),
        .i_hold   (stall_in),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_busy   (w_mul_busy),
        .o_done   (w_mul_done),
        .o_result (w_mul_result)
    );

    always_comb begin
        w_ex_single = '0;
        w_ex_single[EXM_MEM_LSB +: 3]     = cont_MEM_in;
        w_ex_single[EXM_WB_LSB +: 2]      = contWB_in;
        w_ex_single[EXM_TGT_LSB +: TGT_W] = w_tgt;
        w_ex_single[EXM_ZERO]             = (w_alu == 32'd0);
        w_ex_single[EXM_ALU_LSB +: 32]    = w_alu;
        w_ex_single[EXM_WD_LSB +: 32]     = w_b_fwd;
        w_ex_single[EXM_RD_LSB +: 5]      = w_dest;

        w_ex_mul = '0;
        w_ex_mul[EXM_MEM_LSB +: 3]     = r_m_mem;
        w_ex_mul[EXM_WB_LSB +: 2]      = r_m_wb;
        w_ex_mul[EXM_TGT_LSB +: TGT_W] = r_m_tgt;
        w_ex_mul[EXM_ZERO]             = (w_mul_result == 32'd0);
        w_ex_mul[EXM_ALU_LSB +: 32]    = w_mul_result;
        w_ex_mul[EXM_WD_LSB +: 32]     = r_m_wdata;
        w_ex_mul[EXM_RD_LSB +: 5]      = r_m_dest;
    end

    // Side fields of the MUL instruction, captured with its operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_mem   <= '0;
            r_m_wb    <= '0;
            r_m_tgt   <= '0;
            r_m_wdata <= '0;
            r_m_dest  <= '0;
        end else if (w_start) begin
            r_m_mem   <= cont_MEM_in;
            r_m_wb    <= contWB_in;
            r_m_tgt   <= w_tgt;
            r_m_wdata <= w_b_fwd;
            r_m_dest  <= w_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_mem   <= '0;
            r_post_mul <= 1'b0;
        end else if (flush) begin
            r_ex_mem   <= '0;
            r_post_mul <= 1'b0;
        end else if (stall_in) begin
            r_ex_mem   <= r_ex_mem;
        end else if (w_mul_done) begin
            r_ex_mem   <= w_ex_mul;
            r_post_mul <= 1'b1;
        end else if (w_start || w_mul_busy || r_post_mul) begin
            r_ex_mem   <= '0;
            r_post_mul <= 1'b0;
        end else begin
            r_ex_mem   <= w_ex_single;
        end
    end

    assign EX_MEM  = r_ex_mem;
    assign ex_busy = w_mul_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  cont_MEM_in;
    logic [1:0]  contWB_in;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic [31:0] MEM_ALUout;
    logic [31:0] WB_data;
    logic        stall_in;
    logic        flush;
    logic [86:0] EX_MEM;
    logic        ex_busy;

    int n_tests;
    int n_fail;

    ex_stage dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .cont_MEM_in (cont_MEM_in),
        .contWB_in   (contWB_in),
        .pc_plus4    (pc_plus4),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm         (imm),
        .rt_addr     (rt_addr),
        .rd_addr     (rd_addr),
        .fwdA        (fwdA),
        .fwdB        (fwdB),
        .MEM_ALUout  (MEM_ALUout),
        .WB_data     (WB_data),
        .stall_in    (stall_in),
        .flush       (flush),
        .EX_MEM      (EX_MEM),
        .ex_busy     (ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_op = 4'd0; alu_src = 1'b0; reg_dst = 1'b0;
        cont_MEM_in = 3'b000; contWB_in = 2'b00;
        pc_plus4 = 32'd0; rs_data = 32'd0; rt_data = 32'd0; imm = 32'd0;
        rt_addr = 5'd0; rd_addr = 5'd0; fwdA = 2'b00; fwdB = 2'b00;
        MEM_ALUout = 32'd0; WB_data = 32'd0; stall_in = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        alu_op = 4'd6; rs_data = 32'd3; rt_data = 32'd3;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        alu_op = 4'd0;
        n_tests++;
        if (EX_MEM !== 87'd0) begin
            n_fail++; $display("FAIL reset_exmem got %h want 0", EX_MEM);
        end
        n_tests++;
        if (ex_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", ex_busy);
        end
    endtask

    task automatic test_add_forward();
        logic [86:0] exp;
        idle_inputs();
        alu_op = 4'd0; fwdA = 2'b10; MEM_ALUout = 32'd5; rs_data = 32'd99;
        imm = 32'd7; alu_src = 1'b1; fwdB = 2'b00; rt_data = 32'h55;
        reg_dst = 1'b1; rd_addr = 5'd9; rt_addr = 5'd3; contWB_in = 2'b10;
        tick();
        // tgt = (0 + 28)[13:2] = 7
        exp = {3'b000, 2'b10, 12'h007, 1'b0, 32'd12, 32'h55, 5'd9};
        n_tests++;
        if (EX_MEM !== exp) begin
            n_fail++; $display("FAIL add_fwd got %h want %h", EX_MEM, exp);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        alu_op = 4'd1; rs_data = 32'd8; rt_data = 32'd8; alu_src = 1'b0;
        cont_MEM_in = 3'b100; pc_plus4 = 32'h100; imm = 32'd3;
        tick();
        n_tests++;
        if (EX_MEM[69] !== 1'b1) begin
            n_fail++; $display("FAIL beq_zero got %b want 1", EX_MEM[69]);
        end
        n_tests++;
        if (EX_MEM[81:70] !== 12'h043) begin
            n_fail++; $display("FAIL beq_tgt got %h want 043", EX_MEM[81:70]);
        end
        n_tests++;
        if (EX_MEM[86:84] !== 3'b100) begin
            n_fail++; $display("FAIL beq_mem got %b want 100", EX_MEM[86:84]);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [8];
        logic [31:0] av  [8];
        logic [31:0] bv  [8];
        logic [31:0] ev  [8];
        ops = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd4, 4'd0, 4'd9};
        av  = '{32'd5, 32'hF0F0, 32'hF0F0, 32'd0, 32'd1, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd3};
        bv  = '{32'd7, 32'hFF00, 32'hFF00, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd4};
        ev  = '{32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'd7};
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            alu_op = ops[i]; rs_data = av[i]; rt_data = bv[i];
            tick();
            n_tests++;
            if (EX_MEM[68:37] !== ev[i] || EX_MEM[69] !== (ev[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL alu_op%0d_case%0d got %h z=%b want %h", ops[i], i,
                         EX_MEM[68:37], EX_MEM[69], ev[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        alu_op = 4'd0; fwdA = 2'b11; rs_data = 32'd100; WB_data = 32'd1000;
        fwdB = 2'b10; MEM_ALUout = 32'd20; rt_data = 32'd7; rt_addr = 5'd6;
        tick();
        n_tests++;
        if (EX_MEM[68:37] !== 32'd120 || EX_MEM[36:5] !== 32'd20 || EX_MEM[4:0] !== 5'd6) begin
            n_fail++;
            $display("FAIL fwd_11_10 got alu=%0d wd=%0d rd=%0d want 120 20 6",
                     EX_MEM[68:37], EX_MEM[36:5], EX_MEM[4:0]);
        end
        fwdA = 2'b01; fwdB = 2'b01; WB_data = 32'd4;
        tick();
        n_tests++;
        if (EX_MEM[68:37] !== 32'd8 || EX_MEM[36:5] !== 32'd4) begin
            n_fail++;
            $display("FAIL fwd_01 got alu=%0d wd=%0d want 8 4", EX_MEM[68:37], EX_MEM[36:5]);
        end
    endtask

    task automatic test_mul();
        int n;
        int bad;
        logic [86:0] exp;
        idle_inputs();
        alu_op = 4'd6; rs_data = 32'd7; rt_data = 32'd6; reg_dst = 1'b0;
        rt_addr = 5'd4; rd_addr = 5'd17; contWB_in = 2'b10; pc_plus4 = 32'h40;
        tick();
        rs_data = 32'd1000; rt_data = 32'd1000;
        n = 0; bad = 0;
        while (ex_busy === 1'b1 && n < 40) begin
            if (EX_MEM[86:82] !== 5'd0) bad++;
            n++;
            tick();
        end
        n_tests++;
        if (n !== 32) begin
            n_fail++; $display("FAIL mul_busy_cycles got %0d want 32", n);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL mul_bubble_ctrl got %0d nonzero want 0", bad);
        end
        // tgt = 0x40[13:2] = 0x010; wdata = latched rt 6
        exp = {3'b000, 2'b10, 12'h010, 1'b0, 32'd42, 32'd6, 5'd4};
        n_tests++;
        if (EX_MEM !== exp) begin
            n_fail++; $display("FAIL mul_result got %h want %h", EX_MEM, exp);
        end
        tick();
        n_tests++;
        if (ex_busy !== 1'b0 || EX_MEM[86:82] !== 5'd0) begin
            n_fail++;
            $display("FAIL mul_no_restart got busy=%b ctrl=%b want 0 0", ex_busy, EX_MEM[86:82]);
        end
        alu_op = 4'd0; rs_data = 32'd2; rt_data = 32'd3;
        tick();
        n_tests++;
        if (EX_MEM[68:37] !== 32'd5 || EX_MEM[83:82] !== 2'b10) begin
            n_fail++;
            $display("FAIL mul_then_add got %0d wb=%b want 5 10", EX_MEM[68:37], EX_MEM[83:82]);
        end
    endtask

    task automatic test_mul_stall();
        int n;
        idle_inputs();
        alu_op = 4'd6; rs_data = 32'd3; rt_data = 32'd5; contWB_in = 2'b10; rt_addr = 5'd2;
        tick();
        n = 0;
        while (ex_busy === 1'b1 && n < 40) begin
            n++;
            stall_in = (n >= 2 && n < 7);
            tick();
        end
        stall_in = 1'b0;
        n_tests++;
        if (n !== 32 || EX_MEM[68:37] !== 32'd15) begin
            n_fail++;
            $display("FAIL mul_stall_mid got cycles=%0d alu=%0d want 32 15", n, EX_MEM[68:37]);
        end
        alu_op = 4'd0;
        tick();
    endtask

    task automatic test_mul_flush();
        int bad;
        idle_inputs();
        alu_op = 4'd6; rs_data = 32'hFFFFFFFF; rt_data = 32'd2;
        contWB_in = 2'b10; cont_MEM_in = 3'b001;
        tick();
        repeat (9) tick();
        flush = 1'b1;
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (ex_busy !== 1'b0 || EX_MEM[86:82] !== 5'd0) begin
            n_fail++;
            $display("FAIL mul_flush got busy=%b ctrl=%b want 0 0", ex_busy, EX_MEM[86:82]);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (EX_MEM[68:37] === 32'hFFFFFFFE || ex_busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL mul_flush_no_result got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        alu_op = 4'd4; rs_data = 32'hFFFFFFFF; rt_data = 32'd1; contWB_in = 2'b10;
        reg_dst = 1'b1; rd_addr = 5'd7;
        tick();
        n_tests++;
        if (EX_MEM[68:37] !== 32'd1) begin
            n_fail++; $display("FAIL slt_neg got %0d want 1", EX_MEM[68:37]);
        end
        stall_in = 1'b1; alu_op = 4'd0; rs_data = 32'd5; rt_data = 32'd5; rd_addr = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (EX_MEM[68:37] !== 32'd1 || EX_MEM[4:0] !== 5'd7 || EX_MEM[83:82] !== 2'b10) begin
                n_fail++;
                $display("FAIL stall_hold%0d got alu=%0d rd=%0d want 1 7", i, EX_MEM[68:37], EX_MEM[4:0]);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (EX_MEM[86:82] !== 5'd0) begin
            n_fail++; $display("FAIL flush_over_stall got %b want 00000", EX_MEM[86:82]);
        end
        alu_op = 4'd6; rs_data = 32'd2;
        tick();
        n_tests++;
        if (ex_busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_deferred_by_stall got busy=%b want 0", ex_busy);
        end
        stall_in = 1'b0;
        tick();
        n_tests++;
        if (ex_busy !== 1'b1) begin
            n_fail++; $display("FAIL mul_start_after_stall got busy=%b want 1", ex_busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        alu_op = 4'd0;
    endtask

    task automatic test_reset_mid_mul();
        idle_inputs();
        alu_op = 4'd6; rs_data = 32'd9; rt_data = 32'd9; contWB_in = 2'b10;
        tick();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        alu_op = 4'd0; rs_data = 32'd2; rt_data = 32'd3;
        n_tests++;
        if (EX_MEM !== 87'd0 || ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul got exmem=%h busy=%b want 0 0", EX_MEM, ex_busy);
        end
        tick();
        n_tests++;
        if (EX_MEM[68:37] !== 32'd5 || ex_busy !== 1'b0 || EX_MEM[83:82] !== 2'b10) begin
            n_fail++;
            $display("FAIL add_after_reset got %0d busy=%b want 5 0", EX_MEM[68:37], ex_busy);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle_inputs();
        test_reset();
        test_add_forward();
        test_branch();
        test_alu_ops();
        test_forwarding();
        test_mul();
        test_mul_stall();
        test_mul_flush();
        test_stall();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
